pc_fetch_ctrl: RTL and testbench

Owns the program counter for the 16-bit pipelined CPU. Each cycle it selects between the sequential address (PC+2) and a resolved branch target. Immediate-branch targets come from the branch-address adder, register targets come from the register file. It sources the PC+2 value consumed by that adder one stage later, and it also handles stall, flush and halt sequencing for the fetch stage.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_if.sv | 45 ++++
 rtl/branch_cond_eval.sv | 28 ++
 rtl/pc_fetch_ctrl.sv | 92 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, fetch FSM states and the
// sequential PC increment.
package cpu_pkg;

  localparam int PC_STEP = 2;

  typedef enum logic [2:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OV     = 3'b110,
    CC_UNCOND = 3'b111
  } cond_code_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: decode/hazard-side inputs and PC/redirect outputs.
// Optional macro BR_STATS_EN adds the taken-branch counter.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic              br_valid;
  logic              br_is_reg;
  logic [2:0]        br_cond;
  logic              flag_z;
  logic              flag_v;
  logic              flag_n;
  logic [ADDR_W-1:0] br_imm_target;
  logic [ADDR_W-1:0] br_reg_target;
  logic              hlt_fetched;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus2;
  logic              br_taken;
  logic              flush;
  logic              halted;
`ifdef BR_STATS_EN
  logic [15:0]       br_taken_cnt;
`endif

  // Pipeline / hazard side drives branch info and reads the fetch address.
  modport master (
    output stall, br_valid, br_is_reg, br_cond, flag_z, flag_v, flag_n,
           br_imm_target, br_reg_target, hlt_fetched,
`ifdef BR_STATS_EN
    input  br_taken_cnt,
`endif
    input  pc, pc_plus2, br_taken, flush, halted
  );

  // Fetch controller side.
  modport slave (
    input  stall, br_valid, br_is_reg, br_cond, flag_z, flag_v, flag_n,
           br_imm_target, br_reg_target, hlt_fetched,
`ifdef BR_STATS_EN
    output br_taken_cnt,
`endif
    output pc, pc_plus2, br_taken, flush, halted
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluator (code + Z/V/N -> taken).
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] br_cond_i,
  input  logic       flag_z_i,
  input  logic       flag_v_i,
  input  logic       flag_n_i,
  output logic       cond_true_o
);

  // Decode the condition code against the current flags.
  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond_code_e'(br_cond_i))
      CC_NE:     cond_true_o = ~flag_z_i;
      CC_EQ:     cond_true_o = flag_z_i;
      CC_GT:     cond_true_o = ~flag_z_i & ~flag_n_i;
      CC_LT:     cond_true_o = flag_n_i;
      CC_GTE:    cond_true_o = flag_z_i | (~flag_z_i & ~flag_n_i);
      CC_LTE:    cond_true_o = flag_n_i | flag_z_i;
      CC_OV:     cond_true_o = flag_v_i;
      CC_UNCOND: cond_true_o = 1'b1;
      default:   cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner for the fetch stage: sequential PC+2, branch
// redirect (immediate or register target), stall hold and terminal halt.
// Optional macro BR_STATS_EN adds a saturating taken-branch counter.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.slave  fif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              cond_true;
  logic              br_taken;
  logic              advance;
  logic [ADDR_W-1:0] target;

  branch_cond_eval u_cond (
    .br_cond_i   (fif.br_cond),
    .flag_z_i    (fif.flag_z),
    .flag_v_i    (fif.flag_v),
    .flag_n_i    (fif.flag_n),
    .cond_true_o (cond_true)
  );

  // Branch resolution is gated by RUN so a halted core never redirects.
  assign br_taken = fif.br_valid & cond_true & (state_q == ST_RUN);
  assign advance  = (state_q == ST_RUN) & ~fif.stall;
  assign target   = fif.br_is_reg ? fif.br_reg_target : fif.br_imm_target;

  // Next PC / state: stall beats branch, branch beats a wrong-path HLT.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (advance) begin
      if (br_taken) begin
        pc_d = target;
      end else if (fif.hlt_fetched) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + STEP;
      end
    end
  end

  // State, PC and halt flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign fif.pc       = pc_q;
  assign fif.pc_plus2 = pc_q + STEP;
  assign fif.br_taken = br_taken;
  assign fif.flush    = br_taken & ~fif.stall;
  assign fif.halted   = halted_q;

`ifdef BR_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Count redirects actually committed; saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (fif.flush && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Taken-branch counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'h0000;
    else     cnt_q <= cnt_d;
  end

  assign fif.br_taken_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed stimulus, a behavioural
// reference model checked every cycle, plus literal PC/halt expectations.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_fetch_ctrl_if #(.ADDR_W(16)) fif ();

  pc_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_pc;
  logic        m_halt;
  logic [15:0] m_cnt;

  function automatic logic cond_ok(input logic [2:0] cc, input logic z, input logic v, input logic n);
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_taken();
    return fif.br_valid && !m_halt && cond_ok(fif.br_cond, fif.flag_z, fif.flag_v, fif.flag_n);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc   <= 16'h0000;
      m_halt <= 1'b0;
      m_cnt  <= 16'h0000;
    end else if (!m_halt && !fif.stall) begin
      if (exp_taken()) begin
        m_pc  <= fif.br_is_reg ? fif.br_reg_target : fif.br_imm_target;
        m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      end else if (fif.hlt_fetched) begin
        m_halt <= 1'b1;
      end else begin
        m_pc <= 16'(m_pc + 16'd2);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pc", 32'(fif.pc), 32'(m_pc));
    chk("pc_plus2", 32'(fif.pc_plus2), 32'(16'(m_pc + 16'd2)));
    chk("br_taken", 32'(fif.br_taken), 32'(exp_taken()));
    chk("flush", 32'(fif.flush), 32'(exp_taken() && !fif.stall));
    chk("halted", 32'(fif.halted), 32'(m_halt));
`ifdef BR_STATS_EN
    chk("br_taken_cnt", 32'(fif.br_taken_cnt), 32'(m_cnt));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fif.br_valid    = 1'b0;
    fif.br_is_reg   = 1'b0;
    fif.br_cond     = 3'd0;
    fif.hlt_fetched = 1'b0;
    fif.stall       = 1'b0;
  endtask

  task automatic branch_imm(input logic [15:0] tgt);
    fif.br_valid      = 1'b1;
    fif.br_is_reg     = 1'b0;
    fif.br_cond       = 3'b111;
    fif.br_imm_target = tgt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    fif.flag_z = 1'b0;
    fif.flag_v = 1'b0;
    fif.flag_n = 1'b0;
    fif.br_imm_target = 16'h0000;
    fif.br_reg_target = 16'h0000;
    step();
    step();
    chk("reset_pc", 32'(fif.pc), 32'h0000);
    chk("reset_halted", 32'(fif.halted), 32'h0);
    rst = 1'b0;

    // Free run 0,2,4,6,8 and on to 0x10.
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("freerun_pc", 32'(fif.pc), 32'(i * 2));
    end
    for (int i = 0; i < 4; i++) step();
    chk("pc_at_10", 32'(fif.pc), 32'h0010);

    // BEQ taken with Z=1.
    fif.br_valid = 1'b1; fif.br_cond = 3'b001; fif.flag_z = 1'b1;
    fif.br_imm_target = 16'h0040;
    #1 chk("beq_flush", 32'(fif.flush), 32'h1);
    step();
    chk("beq_taken_pc", 32'(fif.pc), 32'h0040);
    // Same branch with Z=0: falls through.
    fif.flag_z = 1'b0;
    #1 chk("beq_nt_flush", 32'(fif.flush), 32'h0);
    step();
    chk("beq_nt_pc", 32'(fif.pc), 32'h0042);

    // Stalled branch: hold two cycles, then redirect once.
    branch_imm(16'h0100);
    fif.stall = 1'b1;
    step();
    step();
    chk("stall_pc", 32'(fif.pc), 32'h0042);
    fif.stall = 1'b0;
    step();
    chk("stall_redirect_pc", 32'(fif.pc), 32'h0100);
    idle();
    step();

    // Condition sweep while stalled: br_taken checked, PC frozen.
    fif.stall = 1'b1;
    fif.br_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        fif.br_cond = 3'(c);
        {fif.flag_z, fif.flag_v, fif.flag_n} = 3'(f);
        step();
      end
    end
    fif.br_cond = 3'b100; fif.flag_z = 1'b0; fif.flag_v = 1'b0; fif.flag_n = 1'b1;
    #1 chk("gte_neg_taken", 32'(fif.br_taken), 32'h0);
    fif.br_cond = 3'b010; fif.flag_n = 1'b0;
    #1 chk("gt_pos_taken", 32'(fif.br_taken), 32'h1);
    idle();
    step();

    // BR register target wins over same-cycle HLT.
    fif.br_valid = 1'b1; fif.br_is_reg = 1'b1; fif.br_cond = 3'b111;
    fif.br_reg_target = 16'h1234; fif.hlt_fetched = 1'b1;
    step();
    chk("br_reg_pc", 32'(fif.pc), 32'h1234);
    chk("br_reg_not_halted", 32'(fif.halted), 32'h0);
    idle();

    // Go to 0x20 and halt there.
    branch_imm(16'h0020);
    step();
    idle();
    fif.hlt_fetched = 1'b1;
    step();
    chk("halt_set", 32'(fif.halted), 32'h1);
    chk("halt_pc", 32'(fif.pc), 32'h0020);
    for (int i = 0; i < 10; i++) begin
      fif.br_valid = i[0];
      fif.br_cond  = 3'b111;
      fif.br_imm_target = 16'h0300;
      step();
    end
    chk("halt_hold_pc", 32'(fif.pc), 32'h0020);
    chk("halt_hold_halted", 32'(fif.halted), 32'h1);
    idle();

    // Asynchronous reset mid-halt.
    rst = 1'b1;
    #2;
    chk("async_rst_pc", 32'(fif.pc), 32'h0000);
    chk("async_rst_halted", 32'(fif.halted), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_pc", 32'(fif.pc), 32'h0002);

    // Wrap-around from 0xFFFE; odd target passes through.
    branch_imm(16'hFFFE);
    step();
    idle();
    chk("wrap_pre_pc", 32'(fif.pc), 32'hFFFE);
    step();
    chk("wrap_pc", 32'(fif.pc), 32'h0000);
    branch_imm(16'h0101);
    step();
    chk("odd_target_pc", 32'(fif.pc), 32'h0101);
    idle();

    // Three taken branches after reset, one stalled a cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    branch_imm(16'h0300);
    step();
    branch_imm(16'h0400);
    fif.stall = 1'b1;
    step();
    fif.stall = 1'b0;
    step();
    branch_imm(16'h0500);
    step();
    idle();
    chk("three_br_pc", 32'(fif.pc), 32'h0500);
`ifdef BR_STATS_EN
    chk("br_taken_cnt_3", 32'(fif.br_taken_cnt), 32'd3);
`endif
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
